// File: rtl/dmac_ch0_master_if.sv
// AHB master-side bus bundle between the DMAC channel-0 engine and the bus.
// The engine uses the master modport; arbiter/slave models use the slave one.
interface dmac_ch0_master_if #(
    parameter int ADDR_W = 32
);
    logic              m_HGRANT;
    logic              m_HREADY;
    logic [1:0]        m_HRESP;
    logic [ADDR_W-1:0] m_HRDATA;
    logic              m_HBUSREQ;
    logic [ADDR_W-1:0] m_HADDR;
    logic [1:0]        m_HTRANS;
    logic              m_HWRITE;
    logic [2:0]        m_HSIZE;
    logic [2:0]        m_HBURST;
    logic [ADDR_W-1:0] m_HWDATA;

    modport master (
        input  m_HGRANT, m_HREADY, m_HRESP, m_HRDATA,
        output m_HBUSREQ, m_HADDR, m_HTRANS, m_HWRITE,
        output m_HSIZE, m_HBURST, m_HWDATA
    );

    modport slave (
        output m_HGRANT, m_HREADY, m_HRESP, m_HRDATA,
        input  m_HBUSREQ, m_HADDR, m_HTRANS, m_HWRITE,
        input  m_HSIZE, m_HBURST, m_HWDATA
    );
endinterface

// File: rtl/dmac_ch0_master.sv
// Channel-0 DMA engine: copies TransferSize words as AHB SINGLE read/write
// pairs, reporting completion, errors and channel-enable clears to the bank.
module dmac_ch0_master #(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 12,
    parameter int ADDR_STEP = 4
) (
    input  logic              m_HCLK,
    input  logic              m_HRESET,
    input  logic [31:0]       DMAC_Configuration,
    input  logic [ADDR_W-1:0] DMAC_C0_SrcAddr,
    input  logic [ADDR_W-1:0] DMAC_C0_DestAddr,
    input  logic [31:0]       DMAC_C0_Control,
    input  logic [31:0]       DMAC_C0_Configuration,
    dmac_ch0_master_if.master bus,
    output logic              ch_active,
    output logic              tc_done,
    output logic              dma_err,
    output logic              clr_ch_en
);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_A,
        S_RD_D,
        S_WR_A,
        S_WR_D,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [ADDR_W-1:0] buf_q, buf_d;
    logic              si_q, si_d;
    logic              di_q, di_d;
    logic              ien_q, ien_d;

    logic enabled;
    logic resp_ok;
    logic resp_err;
    logic unused_bits;

    assign enabled  = DMAC_Configuration[0] & DMAC_C0_Configuration[0];
    assign resp_ok  = bus.m_HREADY & (bus.m_HRESP == RSP_OKAY);
    assign resp_err = (bus.m_HRESP == RSP_ERROR);

    assign unused_bits = ^{DMAC_Configuration[31:1],
                           DMAC_C0_Configuration[31:1],
                           DMAC_C0_Control[31:15]};

    assign bus.m_HSIZE  = 3'b010;
    assign bus.m_HBURST = 3'b000;
    assign ch_active    = (state_q != S_IDLE);

    always_ff @(posedge m_HCLK or posedge m_HRESET) begin
        if (m_HRESET) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            remain_q  <= '0;
            buf_q     <= '0;
            si_q      <= 1'b0;
            di_q      <= 1'b0;
            ien_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            remain_q  <= remain_d;
            buf_q     <= buf_d;
            si_q      <= si_d;
            di_q      <= di_d;
            ien_q     <= ien_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_ptr_d     = src_ptr_q;
        dst_ptr_d     = dst_ptr_q;
        remain_d      = remain_q;
        buf_d         = buf_q;
        si_d          = si_q;
        di_d          = di_q;
        ien_d         = ien_q;
        bus.m_HBUSREQ = 1'b0;
        bus.m_HADDR   = '0;
        bus.m_HTRANS  = HT_IDLE;
        bus.m_HWRITE  = 1'b0;
        bus.m_HWDATA  = '0;
        tc_done       = 1'b0;
        dma_err       = 1'b0;
        clr_ch_en     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enabled) begin
                    src_ptr_d = DMAC_C0_SrcAddr;
                    dst_ptr_d = DMAC_C0_DestAddr;
                    remain_d  = DMAC_C0_Control[CNT_W-1:0];
                    si_d      = DMAC_C0_Control[12];
                    di_d      = DMAC_C0_Control[13];
                    ien_d     = DMAC_C0_Control[14];
                    if (DMAC_C0_Control[CNT_W-1:0] == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_REQ;
                end
            end
            S_REQ: begin
                bus.m_HBUSREQ = 1'b1;
                if (bus.m_HGRANT && bus.m_HREADY)
                    state_d = S_RD_A;
            end
            S_RD_A: begin
                bus.m_HBUSREQ = 1'b1;
                bus.m_HADDR   = src_ptr_q;
                bus.m_HTRANS  = HT_NONSEQ;
                state_d       = S_RD_D;
            end
            S_RD_D: begin
                bus.m_HBUSREQ = 1'b1;
                if (resp_err) begin
                    state_d = S_ERR;
                end else if (resp_ok) begin
                    buf_d   = bus.m_HRDATA;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: begin
                bus.m_HBUSREQ = 1'b1;
                // Without grant the write address phase simply waits here.
                if (bus.m_HGRANT) begin
                    bus.m_HADDR  = dst_ptr_q;
                    bus.m_HTRANS = HT_NONSEQ;
                    bus.m_HWRITE = 1'b1;
                    state_d      = S_WR_D;
                end
            end
            S_WR_D: begin
                bus.m_HBUSREQ = 1'b1;
                bus.m_HWDATA  = buf_q;
                if (resp_err) begin
                    state_d = S_ERR;
                end else if (resp_ok) begin
                    remain_d = remain_q - CNT_W'(1);
                    if (si_q)
                        src_ptr_d = src_ptr_q + ADDR_W'(ADDR_STEP);
                    if (di_q)
                        dst_ptr_d = dst_ptr_q + ADDR_W'(ADDR_STEP);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else if (!enabled) begin
                        clr_ch_en = 1'b1;
                        state_d   = S_IDLE;
                    end else if (bus.m_HGRANT) begin
                        state_d = S_RD_A;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                clr_ch_en = 1'b1;
                tc_done   = ien_q;
                state_d   = S_IDLE;
            end
            S_ERR: begin
                dma_err   = 1'b1;
                clr_ch_en = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: doc/dmac_ch0_master.md
Name: dmac_ch0_master

Overview:
- Single-channel DMA transfer engine on the AHB master side of the DMAC.
- Consumes the channel-0 register-bank values that the DMAC AHB slave programs: global config, source address, destination address, control, channel config.
- Moves TransferSize 32-bit words from source to destination as a read-then-write pair of AHB SINGLE transfers per word.
- Returns completion and error pulses to the register bank, which sets DMACINTR_pend and clears the channel enable.

Parameters:
- ADDR_W, 32, AHB address and data width.
- CNT_W, 12, width of the transfer-size field and the remaining-word counter.
- ADDR_STEP, 4, byte increment applied per word when increment is enabled.

Ports:
- m_HCLK  in  1  bus clock.
- m_HRESET  in  1  asynchronous, active-high reset.
- DMAC_Configuration  in  32  bit[0] = DMAC global enable (E).
- DMAC_C0_SrcAddr  in  32  start source byte address.
- DMAC_C0_DestAddr  in  32  start destination byte address.
- DMAC_C0_Control  in  32  [11:0] TransferSize in words; [12] SI (source increment); [13] DI (destination increment); [14] I (terminal-count interrupt enable).
- DMAC_C0_Configuration  in  32  bit[0] = channel enable (CE).
- m_HGRANT  in  1  arbiter grant.
- m_HREADY  in  1  bus ready.
- m_HRESP  in  2  slave response; OKAY = 2'b00, ERROR = 2'b01.
- m_HRDATA  in  32  read data.
- m_HBUSREQ  out  1  bus request.
- m_HADDR  out  32  address.
- m_HTRANS  out  2  transfer type; only IDLE = 2'b00 and NONSEQ = 2'b10 are used.
- m_HWRITE  out  1  write strobe.
- m_HSIZE  out  3  fixed at 3'b010.
- m_HBURST  out  3  fixed at 3'b000 (SINGLE).
- m_HWDATA  out  32  write data.
- ch_active  out  1  high while the engine is not in IDLE.
- tc_done  out  1  one-cycle pulse on normal completion, qualified by I.
- dma_err  out  1  one-cycle pulse on an ERROR response.
- clr_ch_en  out  1  one-cycle pulse telling the register bank to clear CE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0, except m_HSIZE = 3'b010 and m_HBURST = 3'b000, which are constant.
  - Internal src_ptr, dst_ptr, remaining count and data buffer reset to 0.
  - FSM resets to IDLE.
- Reset mid-transfer: immediate return to IDLE with m_HTRANS = IDLE. No tc_done, dma_err or clr_ch_en pulse.
- States: IDLE, REQ, RD_A, RD_D, WR_A, WR_D, DONE, ERR.
- IDLE:
  - On DMAC_Configuration[0] && DMAC_C0_Configuration[0]: latch SrcAddr, DestAddr, Control[11:0], SI, DI, I.
  - If TransferSize = 0, go to DONE. Otherwise go to REQ.
- REQ:
  - m_HBUSREQ = 1.
  - Go to RD_A when m_HGRANT && m_HREADY are sampled high.
- RD_A:
  - Drive m_HADDR = src_ptr, m_HTRANS = NONSEQ, m_HWRITE = 0 for exactly one cycle, then go to RD_D.
- RD_D:
  - Drive m_HTRANS = IDLE.
  - When m_HREADY = 1 and m_HRESP = OKAY: capture m_HRDATA into the buffer and go to WR_A.
- WR_A:
  - Entered only when m_HGRANT = 1; otherwise hold in WR_A with m_HTRANS = IDLE.
  - Drive m_HADDR = dst_ptr, m_HTRANS = NONSEQ, m_HWRITE = 1, then go to WR_D.
- WR_D:
  - m_HWDATA = buffer, held stable until m_HREADY = 1.
  - On completion with OKAY:
    - Decrement remaining.
    - src_ptr += ADDR_STEP if SI; dst_ptr += ADDR_STEP if DI.
    - Pointers wrap modulo 2^32.
    - Next state: DONE if remaining becomes 0; else IDLE-check (below).
- IDLE-check between words:
  - If CE or E has dropped: go to IDLE with no tc_done, and pulse clr_ch_en.
  - Otherwise go to RD_A if still granted, else REQ.
- Disable mid-word: a word already started always completes both its read and its write.
- m_HBUSREQ is held from REQ through the last WR_D.
- Error handling:
  - m_HRESP = ERROR seen in RD_D or WR_D, in either cycle of the two-cycle response: go to ERR.
  - m_HTRANS = IDLE is driven in the same cycle, so no new address phase is ever issued.
  - A failed read never proceeds to the write.
- ERR: pulse dma_err and clr_ch_en for one cycle, drop m_HBUSREQ, go to IDLE.
- DONE: pulse clr_ch_en, pulse tc_done if I = 1, drop m_HBUSREQ, go to IDLE.
- Latency:
  - Zero-wait slaves with grant held: 4 cycles per word (RD_A, RD_D, WR_A, WR_D).
  - First RD_A occurs 2 cycles after enable is sampled, through IDLE and REQ.
- Latched parameters: register-bank changes during a transfer are ignored, except E and CE, which are checked only at word boundaries.

Test Plan:
- Src 0x0000_1000, dst 0x0000_2000, size 3, SI = DI = I = 1, zero-wait slave -> reads at 0x1000/0x1004/0x1008, writes at 0x2000/0x2004/0x2008 carrying the read data; tc_done and clr_ch_en pulse once, 14 cycles after enable.
- SI = 0, DI = 1, size 2, src 0x4000 -> both reads at 0x4000, writes at dst and dst+4; with I = 0, no tc_done but clr_ch_en pulses.
- Slave returns ERROR on the 2nd read (two-cycle response) -> no write for word 2; dma_err and clr_ch_en pulse; m_HTRANS = IDLE from the first ERROR cycle; m_HBUSREQ drops.
- m_HREADY low for 3 cycles in WR_D, plus m_HGRANT removed before the 2nd WR_A -> m_HWDATA held stable; no NONSEQ issued until grant returns; data intact.
- CE cleared during word 2 of 4 -> word 2 completes, word 3 never starts, no tc_done, clr_ch_en pulses; size 0 -> no bus request, DONE pulses immediately.
- dst 0xFFFF_FFFC, DI = 1, size 2 -> second write at 0x0000_0000; m_HRESET asserted mid RD_D -> all outputs return to reset values asynchronously.
